mem_read_requester: RTL and testbench

- Read side of the memory address FIFOs that the A and B address generators fill.
- Pops one word address at a time and issues a read request to the memory port with a req/gnt handshake.
- Tracks in-order outstanding reads up to a credit limit.
- Forwards each returned line, registered, as data plus a one-cycle valid strobe to the operand buffer write port.
- One instance per operand (A and B).

---
 rtl/mem_read_pkg.sv | 21 ++
 rtl/mem_read_requester_credit_counter.sv | 41 ++++
 rtl/mem_read_requester.sv | 164 ++++++++++++++++
 tb/tb_mem_read_requester.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_pkg.sv
// Shared types and defaults for the memory read requester.
// Contents: FSM state enum, default parameter values, and the width helper
// for the outstanding-read counter.
package mem_read_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int DEF_ADDR_WIDTH           = 16;
    localparam int DEF_MEM_DATA_WIDTH_BYTES = 32;
    localparam int DEF_MAX_OUTSTANDING      = 4;

    // Counter must represent 0..max_out inclusive.
    function automatic int cnt_width(input int max_out);
        return (max_out < 1) ? 1 : $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/mem_read_requester_credit_counter.sv
// Outstanding-read counter for the read requester.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   inc_i            a request was granted this cycle
//   dec_i            a read response returned this cycle (caller guards zero)
//   count_o          current number of granted-but-unreturned reads
//   full_o           count_o == MAX_OUTSTANDING
//   zero_o           count_o == 0
module credit_counter
    import mem_read_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] r_count;

    // Simultaneous inc and dec cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc_i && !dec_i) begin
            r_count <= r_count + CNT_W'(1);
        end else if (dec_i && !inc_i) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign count_o = r_count;
    assign full_o  = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign zero_o  = (r_count == '0);

endmodule

// File: rtl/mem_read_requester.sv
// Read side of an operand address FIFO: pops word addresses, issues reads
// over a req/gnt handshake, tracks in-order outstanding reads against a
// credit limit, and forwards returned lines to the operand buffer.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start_i, clear_i    begin fetching / stop fetching and drain
//   fifo_addr_i         FWFT head of the address FIFO
//   fifo_empty_i        address FIFO empty
//   fifo_pop_o          pop the FIFO head this cycle
//   mem_req_o           read request valid (held until granted)
//   mem_addr_o          read address
//   mem_gnt_i           request accepted this cycle
//   mem_rvalid_i        in-order read return
//   mem_rdata_i         read data
//   data_o, valid_o     registered data and one-cycle write strobe
//   busy_o              not idle
//   err_o               sticky: return with nothing outstanding
module mem_read_requester
    import mem_read_pkg::*;
#(
    parameter int ADDR_WIDTH           = DEF_ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH_BYTES = DEF_MEM_DATA_WIDTH_BYTES,
    parameter int MAX_OUTSTANDING      = DEF_MAX_OUTSTANDING
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start_i,
    input  logic                              clear_i,
    input  logic [ADDR_WIDTH-1:0]             fifo_addr_i,
    input  logic                              fifo_empty_i,
    output logic                              fifo_pop_o,
    output logic                              mem_req_o,
    output logic [ADDR_WIDTH-1:0]             mem_addr_o,
    input  logic                              mem_gnt_i,
    input  logic                              mem_rvalid_i,
    input  logic [MEM_DATA_WIDTH_BYTES*8-1:0] mem_rdata_i,
    output logic [MEM_DATA_WIDTH_BYTES*8-1:0] data_o,
    output logic                              valid_o,
    output logic                              busy_o,
    output logic                              err_o
);

    localparam int DW    = MEM_DATA_WIDTH_BYTES * 8;
    localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  r_pending;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DW-1:0]         r_data;
    logic                  r_valid;
    logic                  r_err;

    logic [CNT_W-1:0]      w_cnt;
    logic                  w_full;
    logic                  w_zero;
    logic                  w_grant;
    logic                  w_dec;
    logic                  w_stray;
    logic                  w_credit_ok;
    logic                  w_pop;

    assign w_grant = r_pending && mem_gnt_i;
    assign w_dec   = mem_rvalid_i && !w_zero;
    assign w_stray = mem_rvalid_i && w_zero;

    // Equivalent to count + pending < MAX_OUTSTANDING, given count <= MAX.
    // A same-cycle return is deliberately not credited.
    assign w_credit_ok = !w_full &&
                         !(r_pending && (w_cnt == CNT_W'(MAX_OUTSTANDING - 1)));

    credit_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_credit (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (w_grant),
        .dec_i   (w_dec),
        .count_o (w_cnt),
        .full_o  (w_full),
        .zero_o  (w_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                // clear wins over a coincident start
                if (start_i && !clear_i) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_pop = !fifo_empty_i && (!r_pending || mem_gnt_i) && w_credit_ok;
                if (clear_i) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_pending && w_zero) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request register. A pop in the grant cycle reloads it so requests
    // can issue back to back; an ungranted request is never dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_addr    <= '0;
        end else if (w_pop) begin
            r_pending <= 1'b1;
            r_addr    <= fifo_addr_i;
        end else if (w_grant) begin
            r_pending <= 1'b0;
        end
    end

    // Returns during DRAIN only retire credits; their data is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_dec && (r_state == RUN);
            if (w_dec && (r_state == RUN)) begin
                r_data <= mem_rdata_i;
            end
        end
    end

    // A stray return in the same cycle as start still flags the error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_stray) begin
            r_err <= 1'b1;
        end else if (start_i) begin
            r_err <= 1'b0;
        end
    end

    assign fifo_pop_o = w_pop;
    assign mem_req_o  = r_pending;
    assign mem_addr_o = r_addr;
    assign data_o     = r_data;
    assign valid_o    = r_valid;
    assign busy_o     = (r_state != IDLE);
    assign err_o      = r_err;

endmodule

// File: tb/tb_mem_read_requester.sv
module tb_mem_read_requester;

    localparam int AW      = 16;
    localparam int DB      = 32;
    localparam int DW      = DB * 8;
    localparam int MAXO    = 4;
    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;

    logic          clk = 1'b0;
    logic          reset, start_i, clear_i, fifo_empty_i, fifo_pop_o;
    logic          mem_req_o, mem_gnt_i, mem_rvalid_i, valid_o, busy_o, err_o;
    logic [AW-1:0] fifo_addr_i, mem_addr_o;
    logic [DW-1:0] mem_rdata_i, data_o;

    initial forever #5 clk = ~clk;

    mem_read_requester #(
        .ADDR_WIDTH(AW), .MEM_DATA_WIDTH_BYTES(DB), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .clear_i(clear_i),
        .fifo_addr_i(fifo_addr_i), .fifo_empty_i(fifo_empty_i), .fifo_pop_o(fifo_pop_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .data_o(data_o), .valid_o(valid_o), .busy_o(busy_o), .err_o(err_o)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Environment: FIFO contents, expected grant order, in-flight reads.
    logic [AW-1:0] fifo_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [AW-1:0] resp_q[$];
    int            resp_due[$];
    int            last_due = 0;
    int            g_cyc[$];

    // Reference behaviour.
    int            m_out = 0;
    int            phase = P_IDLE;
    logic          m_req = 1'b0;
    logic          m_err = 1'b0;
    logic          exp_v = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] exp_d = '0;

    int lat = 3;
    bit mem_en = 0, force_rv = 0, rnd_gnt = 0, gnt_val = 0;
    int n_grant = 0, n_valid = 0;
    bit last_pop = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
        logic [DW-1:0] d = '0;
        for (int i = 0; i < DW / AW; i++) d[i*AW +: AW] = a ^ AW'(i * 16'h1357);
        return d;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d = '0;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic push(input logic [AW-1:0] a);
        fifo_q.push_back(a);
        exp_addr_q.push_back(a);
    endtask

    // One clock: drive environment, check at negedge, advance the model.
    task automatic cycle();
        bit            rv, g, pop_exp, req0;
        int            ph0, out0, due;
        logic [AW-1:0] ea;
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_addr_i  = fifo_empty_i ? AW'($urandom) : fifo_q[0];
        mem_gnt_i    = rnd_gnt ? ($urandom_range(0, 9) < 7) : gnt_val;
        rv           = force_rv || (mem_en && resp_q.size() > 0 && resp_due[0] <= cyc);
        mem_rvalid_i = rv;
        mem_rdata_i  = (rv && !force_rv) ? mk_data(resp_q[0]) : rnd_data();
        @(negedge clk);
        if (reset) begin
            resp_q.delete(); resp_due.delete(); last_due = 0;
            m_out = 0; phase = P_IDLE; m_req = 0; m_err = 0; exp_v = 0; m_addr = '0;
            exp_addr_q = fifo_q;
            last_pop = 0;
        end else begin
            ph0  = phase;
            out0 = m_out;
            req0 = m_req;
            pop_exp = (ph0 == P_RUN) && (fifo_q.size() > 0) && (!req0 || mem_gnt_i)
                      && (out0 + int'(req0) < MAXO);
            chk("busy_o", DW'(busy_o), DW'(ph0 != P_IDLE));
            chk("err_o", DW'(err_o), DW'(m_err));
            chk("valid_o", DW'(valid_o), DW'(exp_v));
            if (exp_v) chk("data_o", data_o, exp_d);
            chk("mem_req_o", DW'(mem_req_o), DW'(req0));
            if (req0) chk("mem_addr_o", DW'(mem_addr_o), DW'(m_addr));
            chk("fifo_pop_o", DW'(fifo_pop_o), DW'(pop_exp));
            if (valid_o) n_valid++;
            // return first: the stray check uses the pre-grant count
            exp_v = 1'b0;
            if (start_i) m_err = 1'b0;
            if (rv && out0 > 0) begin
                m_out--;
                void'(resp_q.pop_front());
                void'(resp_due.pop_front());
                exp_v = (ph0 == P_RUN);
                exp_d = mem_rdata_i;
            end else if (rv) begin
                m_err = 1'b1;
            end
            g = mem_req_o && mem_gnt_i;
            if (g) begin
                n_grant++;
                g_cyc.push_back(cyc);
                if (exp_addr_q.size() > 0) begin
                    ea = exp_addr_q.pop_front();
                    chk("grant_addr", DW'(mem_addr_o), DW'(ea));
                end else begin
                    ea = mem_addr_o;
                    chk("grant_unexpected", DW'(g), DW'(0));
                end
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                resp_q.push_back(ea);
                resp_due.push_back(due);
                m_out++;
            end
            last_pop = fifo_pop_o;
            if (fifo_pop_o && fifo_q.size() > 0) begin
                m_addr = fifo_q.pop_front();
                m_req  = 1'b1;
            end else if (g) begin
                m_req = 1'b0;
            end
            case (ph0)
                P_IDLE:  if (start_i && !clear_i) phase = P_RUN;
                P_RUN:   if (clear_i) phase = P_DRAIN;
                default: if (!req0 && out0 == 0) phase = P_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Every output must read zero; the model is idle with quiet inputs.
    task automatic chk_zero(input string tag);
        @(negedge clk);
        chk({tag, "_pop"},   DW'(fifo_pop_o), DW'(0));
        chk({tag, "_req"},   DW'(mem_req_o),  DW'(0));
        chk({tag, "_addr"},  DW'(mem_addr_o), DW'(0));
        chk({tag, "_valid"}, DW'(valid_o),    DW'(0));
        chk({tag, "_data"},  data_o,          DW'(0));
        chk({tag, "_busy"},  DW'(busy_o),     DW'(0));
        chk({tag, "_err"},   DW'(err_o),      DW'(0));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int base, nv0, c0;
        bit ok;
        reset = 1; start_i = 0; clear_i = 0; fifo_empty_i = 1; fifo_addr_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
        cycle(); cycle();
        reset = 0;
        chk_zero("reset");

        // 1: three addresses, gnt tied high, latency 3
        push(16'h0010); push(16'h0011); push(16'h0012);
        gnt_val = 1; mem_en = 1; lat = 3; g_cyc.delete(); nv0 = n_valid;
        c0 = cyc;
        start_i = 1; cycle(); start_i = 0;
        for (int k = 0; k < 30 && n_valid - nv0 < 3; k++) cycle();
        chk("t1_valid_count", DW'(n_valid - nv0), DW'(3));
        chk("t1_grant_count", DW'(g_cyc.size()), DW'(3));
        if (g_cyc.size() >= 3) begin
            chk("t1_first_req", DW'(g_cyc[0] - c0), DW'(2));
            chk("t1_b2b_1", DW'(g_cyc[1] - g_cyc[0]), DW'(1));
            chk("t1_b2b_2", DW'(g_cyc[2] - g_cyc[1]), DW'(1));
        end

        // 2: no responses -> credit limit caps grants; one return frees one pop
        mem_en = 0; base = n_grant;
        for (int i = 0; i < 6; i++) push(AW'(16'h0100 + i));
        for (int k = 0; k < 10; k++) cycle();
        chk("t2_grants", DW'(n_grant - base), DW'(MAXO));
        chk("t2_no_req", DW'(mem_req_o), DW'(0));
        chk("t2_no_pop", DW'(last_pop), DW'(0));
        mem_en = 1; cycle(); mem_en = 0;
        chk("t2_pop_same_cycle", DW'(last_pop), DW'(0));
        cycle();
        chk("t2_pop_next_cycle", DW'(last_pop), DW'(1));

        // 3: grant withheld with request up, then released
        mem_en = 1; lat = 2; ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            cycle();
            ok = (m_out == 0) && !m_req && (fifo_q.size() == 0);
        end
        chk("t3_settle", DW'(ok), DW'(1));
        gnt_val = 0;
        for (int i = 0; i < 4; i++) push(AW'(16'h0200 + i));
        cycle();
        chk("t3_first_pop", DW'(last_pop), DW'(1));
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t3_stall_pop", DW'(last_pop), DW'(0));
            chk("t3_stall_req", DW'(mem_req_o), DW'(1));
        end
        gnt_val = 1; base = n_grant;
        for (int k = 0; k < 4; k++) cycle();
        chk("t3_grant_each_cycle", DW'(n_grant - base), DW'(4));

        // 4: clear with one pending and two outstanding
        ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            cycle();
            ok = (m_out == 0) && !m_req && (fifo_q.size() == 0);
        end
        chk("t4_settle", DW'(ok), DW'(1));
        mem_en = 0;
        push(16'h0300); push(16'h0301);
        ok = 0;
        for (int k = 0; k < 10 && !ok; k++) begin
            cycle();
            ok = (m_out == 2) && !m_req;
        end
        chk("t4_two_out", DW'(ok), DW'(1));
        gnt_val = 0;
        push(16'h0302);
        cycle();
        chk("t4_pend_pop", DW'(last_pop), DW'(1));
        push(16'h0310);
        clear_i = 1; cycle(); clear_i = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t4_req_held", DW'(mem_req_o), DW'(1));
            chk("t4_busy", DW'(busy_o), DW'(1));
        end
        gnt_val = 1; cycle(); gnt_val = 0;
        nv0 = n_valid; mem_en = 1; ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            cycle();
            ok = !busy_o;
        end
        chk("t4_drained", DW'(ok), DW'(1));
        chk("t4_no_valid", DW'(n_valid - nv0), DW'(0));

        // 5: stray return in IDLE -> sticky error, cleared by start
        force_rv = 1; cycle(); force_rv = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t5_err_sticky", DW'(err_o), DW'(1));
        end
        gnt_val = 1; lat = 2;
        start_i = 1; cycle(); start_i = 0;
        chk("t5_err_cleared", DW'(err_o), DW'(0));

        // random traffic against the reference model
        rnd_gnt = 1;
        for (int k = 0; k < 400; k++) begin
            if (fifo_q.size() < 6 && $urandom_range(0, 2) != 0) push(AW'($urandom));
            lat     = $urandom_range(1, 6);
            mem_en  = ($urandom_range(0, 4) != 0);
            start_i = ($urandom_range(0, 49) == 0);
            cycle();
        end
        start_i = 0;
        clear_i = 1; cycle(); clear_i = 0;
        mem_en = 1; ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            cycle();
            ok = !busy_o;
        end
        chk("rand_drained", DW'(ok), DW'(1));

        // 6: reset mid-RUN with three outstanding
        rnd_gnt = 0; gnt_val = 1; mem_en = 0;
        fifo_q.delete(); exp_addr_q.delete();
        push(16'h0400); push(16'h0401); push(16'h0402);
        start_i = 1; cycle(); start_i = 0;
        ok = 0;
        for (int k = 0; k < 10 && !ok; k++) begin
            cycle();
            ok = (m_out == 3);
        end
        chk("t6_three_out", DW'(ok), DW'(1));
        reset = 1; cycle(); reset = 0;
        chk_zero("t6");
        // a leftover count would cap grants below the full credit limit
        for (int i = 0; i < 5; i++) push(AW'(16'h0500 + i));
        base = n_grant;
        start_i = 1; cycle(); start_i = 0;
        for (int k = 0; k < 10; k++) cycle();
        chk("t6_counter_cleared", DW'(n_grant - base), DW'(MAXO));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
